// File: rtl/aes_round_engine.sv
// Iterative AES-128 round engine: one round per clock against an external S-box layer and key store.
// Defining AES_ENGINE_DEC_EN adds the decrypt datapath; without it every operation is an encryption.
module aes_round_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         dec_i,
    input  logic [127:0] din_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic [127:0] sb_in_o,
    output logic         sb_dec_o,
    input  logic [127:0] sb_out_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] dout_o
);
    // Element 15 holds FIPS byte 0; byte (row r, column c) sits at index 15 - (4*c + r).
    typedef logic [15:0][7:0] blk_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUND = 1'b1;

    logic [0:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] dout_q, dout_d;
    logic         done_q, done_d;
    logic         mode;
    logic         dec_sel;
    logic         last_rnd;
    logic [127:0] enc_res;
    logic [127:0] round_res;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic blk_t shift_rows(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4'(15 - 4*c - r)] = s[4'(15 - 4*((c + r) % 4) - r)];
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(15 - 4*c)];
            a1 = s[4'(14 - 4*c)];
            a2 = s[4'(13 - 4*c)];
            a3 = s[4'(12 - 4*c)];
            o[4'(15 - 4*c)] = gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3;
            o[4'(14 - 4*c)] = a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3;
            o[4'(13 - 4*c)] = a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3);
            o[4'(12 - 4*c)] = gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2);
        end
        return o;
    endfunction

    // MixColumns is skipped in the last encrypt round.
    assign enc_res = ((rnd_q == 4'd10) ? shift_rows(sb_out_i)
                                       : mix_columns(shift_rows(sb_out_i))) ^ rk_i;

`ifdef AES_ENGINE_DEC_EN
    logic         mode_q, mode_d;
    logic [127:0] dec_t;
    logic [127:0] dec_res;

    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4'(15 - 4*c - r)] = s[4'(15 - 4*((c + 4 - r) % 4) - r)];
        return o;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(15 - 4*c)];
            a1 = s[4'(14 - 4*c)];
            a2 = s[4'(13 - 4*c)];
            a3 = s[4'(12 - 4*c)];
            o[4'(15 - 4*c)] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
            o[4'(14 - 4*c)] = gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
            o[4'(13 - 4*c)] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
            o[4'(12 - 4*c)] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14);
        end
        return o;
    endfunction

    assign dec_sel   = dec_i;
    assign mode      = mode_q;
    assign mode_d    = (fsm_q == ST_IDLE && start_i) ? dec_i : mode_q;
    assign dec_t     = inv_shift_rows(sb_out_i) ^ rk_i;
    assign dec_res   = (rnd_q == 4'd0) ? dec_t : inv_mix_columns(dec_t);
    assign round_res = mode ? dec_res : enc_res;
    assign last_rnd  = mode ? (rnd_q == 4'd0) : (rnd_q == 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= 1'b0;
        else     mode_q <= mode_d;
    end
`else
    logic unused_dec;

    assign unused_dec = dec_i;
    assign dec_sel    = 1'b0;
    assign mode       = 1'b0;
    assign round_res  = enc_res;
    assign last_rnd   = (rnd_q == 4'd10);
`endif

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = din_i ^ rk_i;
                    rnd_d   = dec_sel ? 4'd9 : 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            default: begin
                state_d = round_res;
                rnd_d   = mode ? (rnd_q - 4'd1) : (rnd_q + 4'd1);
                if (last_rnd) begin
                    dout_d = round_res;
                    done_d = 1'b1;
                    rnd_d  = 4'd0;
                    fsm_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= 4'd0;
            state_q <= 128'd0;
            dout_q  <= 128'd0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    // In IDLE the key index anticipates the whitening key of the pending request.
    assign rk_idx_o = (fsm_q == ST_ROUND) ? rnd_q : (dec_sel ? 4'd10 : 4'd0);
    assign sb_in_o  = state_q;
    assign sb_dec_o = mode;
    assign busy_o   = (fsm_q == ST_ROUND);
    assign done_o   = done_q;
    assign dout_o   = dout_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: models the S-box layer and key store, and checks results
// against a byte-grid AES-128 reference (encrypt, plus decrypt when AES_ENGINE_DEC_EN is set).
module tb_aes_round_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         dec_i;
    logic [127:0] din_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic [127:0] sb_in_o;
    logic         sb_dec_o;
    logic [127:0] sb_out_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] dout_o;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef logic [3:0][3:0][7:0] grid_t;   // grid[row][col]

    logic [255:0][7:0]  sbox_tab;
    logic [255:0][7:0]  inv_tab;
    logic [10:0][127:0] rk_tab;
    int                 n_vec = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    aes_round_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .dec_i    (dec_i),
        .din_i    (din_i),
        .rk_idx_o (rk_idx_o),
        .rk_i     (rk_i),
        .sb_in_o  (sb_in_o),
        .sb_dec_o (sb_dec_o),
        .sb_out_i (sb_out_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .dout_o   (dout_o)
    );

    // External key store and S-box layer, both combinational.
    assign rk_i = (rk_idx_o <= 4'd10) ? rk_tab[rk_idx_o] : 128'd0;

    always_comb begin
        sb_out_i = '0;
        for (int i = 0; i < 16; i++)
            sb_out_i[i*8 +: 8] = sb_dec_o ? inv_tab[sb_in_o[i*8 +: 8]] : sbox_tab[sb_in_o[i*8 +: 8]];
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_entry(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        for (int j = 1; j < 256; j++)
            if (gf_mul(v, 8'(j)) == 8'h01) inv = 8'(j);
        s = 8'h63;
        for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
        return s;
    endfunction

    function automatic logic [10:0][127:0] expand_key(input logic [127:0] key);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rcon;
        logic [10:0][127:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]] ^ rcon, sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic grid_t to_grid(input logic [127:0] b);
        grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) g[r][c] = b[127 - 8*(4*c + r) -: 8];
        return g;
    endfunction

    function automatic logic [127:0] from_grid(input grid_t g);
        logic [127:0] b;
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[127 - 8*(4*c + r) -: 8] = g[r][c];
        return b;
    endfunction

    function automatic grid_t sub_bytes(input grid_t g, input logic inv);
        grid_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[r][c] = inv ? inv_tab[g[r][c]] : sbox_tab[g[r][c]];
        return o;
    endfunction

    function automatic grid_t shift(input grid_t g, input logic inv);
        grid_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[r][c] = inv ? g[r][(c + 4 - r) % 4] : g[r][(c + r) % 4];
        return o;
    endfunction

    function automatic grid_t mix(input grid_t g, input logic inv);
        grid_t      o;
        logic [7:0] coef [4];
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                o[r][c] = 8'h00;
                for (int k = 0; k < 4; k++) o[r][c] = o[r][c] ^ gf_mul(coef[(k - r + 4) % 4], g[k][c]);
            end
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [10:0][127:0] rks);
        grid_t g;
        g = to_grid(pt) ^ to_grid(rks[0]);
        for (int n = 1; n <= 10; n++) begin
            g = shift(sub_bytes(g, 1'b0), 1'b0);
            if (n < 10) g = mix(g, 1'b0);
            g = g ^ to_grid(rks[n]);
        end
        return from_grid(g);
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [10:0][127:0] rks);
        grid_t g;
        g = to_grid(ct) ^ to_grid(rks[10]);
        for (int n = 9; n >= 0; n--) begin
            g = sub_bytes(shift(g, 1'b1), 1'b1) ^ to_grid(rks[n]);
            if (n > 0) g = mix(g, 1'b1);
        end
        return from_grid(g);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full operation from IDLE; inputs are scrambled and start is pulsed while busy.
    task automatic run_op(input string tag, input logic [127:0] din, input logic dec,
                          input logic [127:0] exp);
        logic eff_dec;
`ifdef AES_ENGINE_DEC_EN
        eff_dec = dec;
`else
        eff_dec = 1'b0;
`endif
        @(negedge clk);
        start_i = 1'b1;
        dec_i   = dec;
        din_i   = din;
        #1 check({tag, "/idx_idle"}, rk_idx_o, eff_dec ? 128'd10 : 128'd0);
        @(negedge clk);
        din_i = {$urandom, $urandom, $urandom, $urandom};
        dec_i = 1'($urandom_range(0, 1));
        for (int k = 0; k < 10; k++) begin
            check({tag, "/busy"}, busy_o, 1'b1);
            check({tag, "/done_early"}, done_o, 1'b0);
            check({tag, "/rk_idx"}, rk_idx_o, eff_dec ? 9 - k : k + 1);
            check({tag, "/sb_dec"}, sb_dec_o, eff_dec);
            start_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, "/done"}, done_o, 1'b1);
        check({tag, "/busy_end"}, busy_o, 1'b0);
        check({tag, "/dout"}, dout_o, exp);
        @(negedge clk);
        check({tag, "/done_pulse"}, done_o, 1'b0);
        check({tag, "/dout_hold"}, dout_o, exp);
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] key;
        logic [127:0] blk;
        logic [127:0] exp;
        logic         dec;

        rst     = 1'b1;
        start_i = 1'b0;
        dec_i   = 1'b0;
        din_i   = '0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_entry(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = 8'(i);
        rk_tab = expand_key(C1_KEY);

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_dout", dout_o, 128'd0);
        check("rst_state", sb_in_o, 128'd0);
        check("rst_sb_dec", sb_dec_o, 1'b0);
        rst = 1'b0;

        run_op("c1_enc", C1_PT, 1'b0, C1_CT);
`ifdef AES_ENGINE_DEC_EN
        run_op("c1_dec", C1_CT, 1'b1, C1_PT);
`else
        run_op("c1_dec_ignored", C1_PT, 1'b1, C1_CT);
`endif

        // Start held high across two blocks: the second is accepted while done_o is high.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start_i = 1'b1;
        dec_i   = 1'b0;
        din_i   = a;
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            if (c == 0) din_i = b;
            check("b2b_done", done_o, (c == 10 || c == 21));
            if (c == 10) check("b2b_dout_a", dout_o, aes_enc(a, rk_tab));
            if (c == 21) begin
                check("b2b_dout_b", dout_o, aes_enc(b, rk_tab));
                start_i = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done_end", done_o, 1'b0);

        // Abort at round 5 with an asynchronous reset.
        @(negedge clk);
        start_i = 1'b1;
        dec_i   = 1'b0;
        din_i   = C1_PT;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_dout", dout_o, 128'd0);
        check("abort_state", sb_in_o, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_no_done", done_o, 1'b0);
            check("abort_idle", busy_o, 1'b0);
        end
        run_op("after_abort", C1_PT, 1'b0, C1_CT);

        for (int n = 0; n < 10; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            blk = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            rk_tab = expand_key(key);
`ifdef AES_ENGINE_DEC_EN
            exp = dec ? aes_dec(blk, rk_tab) : aes_enc(blk, rk_tab);
`else
            exp = aes_enc(blk, rk_tab);
`endif
            run_op("rand", blk, dec, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
